// File: rtl/add_serial_signed.sv
// Bit-serial signed adder: one full-adder slice, LSB first, WIDTH cycles per op.
// Optional macro ADD_SAT_EN saturates the result on signed overflow.
module add_serial_signed #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends combinationally on ready on either side.

    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;

    logic             w_accept;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry_out;
    logic             w_ovf;
    logic [WIDTH-1:0] w_wrapped;
    logic [WIDTH-1:0] w_final;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign overflow  = r_overflow;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_last      = (r_state == S_RUN) && (r_cnt == LAST);
    assign w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_out = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    // On the last bit r_carry is the carry into the MSB.
    assign w_ovf       = r_carry ^ w_carry_out;
    // Sum bits are shifted into the top of r_a as operand bits leave the bottom.
    assign w_wrapped   = {w_sum_bit, r_a[WIDTH-1:1]};

`ifdef ADD_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // On the last bit r_a[0] still holds the sign bit of A.
    always_comb begin
        w_final = w_wrapped;
        if (w_ovf) begin
            w_final = r_a[0] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign w_final = w_wrapped;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= w_wrapped;
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_carry_out;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_result   <= w_final;
                r_overflow <= w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_add_serial_signed.sv
// Directed bench for add_serial_signed (WIDTH=8), wrapped or saturating build.
module tb_add_serial_signed;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    add_serial_signed #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic eo);
        int lat;
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        A = W'($urandom_range(0, 255));
        B = W'($urandom_range(0, 255));
        check({tag, "_busy"}, 16'(in_ready), 16'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 16'(lat), 16'd8);
        check({tag, "_result"}, 16'(result), 16'(er));
        check({tag, "_overflow"}, 16'(overflow), 16'(eo));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, 16'(out_valid), 16'd0);
        check({tag, "_ready_again"}, 16'(in_ready), 16'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] exp_of;
        logic [W-1:0] b2b_a[4];
        logic [W-1:0] b2b_b[4];
        logic [W-1:0] b2b_r[4];
        int           idx;
        int           got_n;
        int           last_cyc;
        bit           seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 16'(in_ready), 16'd1);
        check("reset_out_valid", 16'(out_valid), 16'd0);
        check("reset_result", 16'(result), 16'd0);
        check("reset_overflow", 16'(overflow), 16'd0);
        rst = 1'b0;

        run_op("t1_100p27", 8'd100, 8'd27, 8'h7F, 1'b0);
`ifdef ADD_SAT_EN
        run_op("t2_100p28", 8'd100, 8'd28, 8'h7F, 1'b1);
`else
        run_op("t2_100p28", 8'd100, 8'd28, 8'h80, 1'b1);
`endif

        // Abort mid-RUN: reset lands on the edge ending the 4th RUN cycle.
        @(negedge clk);
        A = 8'd9; B = 8'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_abort_in_ready", 16'(in_ready), 16'd1);
        check("t5_abort_out_valid", 16'(out_valid), 16'd0);
        check("t5_abort_result", 16'(result), 16'd0);
        check("t5_abort_overflow", 16'(overflow), 16'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t5_no_output", 16'(seen), 16'd0);
        run_op("t5_5pm7", 8'd5, 8'hF9, 8'hFE, 1'b0);

`ifdef ADD_SAT_EN
        exp_of = 8'h80;
`else
        exp_of = 8'h7F;
`endif
        run_op("t3_m128pm1", 8'h80, 8'hFF, exp_of, 1'b1);
        run_op("t3_m1pm1", 8'hFF, 8'hFF, 8'hFE, 1'b0);
        run_op("x_m100pm29", 8'h9C, 8'hE3, exp_of, 1'b1);
`ifdef ADD_SAT_EN
        run_op("x_127p1", 8'h7F, 8'h01, 8'h7F, 1'b1);
`else
        run_op("x_127p1", 8'h7F, 8'h01, 8'h80, 1'b1);
`endif
        run_op("x_m50p20", 8'hCE, 8'h14, 8'hE2, 1'b0);
        run_op("x_64pm64", 8'h40, 8'hC0, 8'h00, 1'b0);

        // Back-pressure: hold DONE for 5 cycles while in_valid pulses.
        @(negedge clk);
        A = 8'd3; B = 8'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        idx = 0;
        while (!out_valid && idx < 20) begin
            @(negedge clk);
            idx++;
        end
        for (int k = 0; k < 5; k++) begin
            A = 8'd99; B = 8'd99; in_valid = k[0];
            check("t4_hold_valid", 16'(out_valid), 16'd1);
            check("t4_hold_result", 16'(result), 16'h07);
            check("t4_hold_overflow", 16'(overflow), 16'd0);
            check("t4_hold_in_ready", 16'(in_ready), 16'd0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("t4_no_bypass", 16'(in_ready), 16'd1);
        check("t4_released", 16'(out_valid), 16'd0);

        // Back-to-back with in_valid held high and out_ready tied high.
        b2b_a[0] = 8'd10;  b2b_b[0] = 8'd20;  b2b_r[0] = 8'd30;
        b2b_a[1] = 8'hFD;  b2b_b[1] = 8'hFC;  b2b_r[1] = 8'hF9;
        b2b_a[2] = 8'h7F;  b2b_b[2] = 8'h80;  b2b_r[2] = 8'hFF;
        b2b_a[3] = 8'hC0;  b2b_b[3] = 8'hC0;  b2b_r[3] = 8'h80;
        out_ready = 1'b1;
        idx = 0; got_n = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 200 && got_n < 4; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check("t6_result", 16'(result), 16'(exp_q.pop_front()));
                end else begin
                    check("t6_spurious", 16'(out_valid), 16'd0);
                end
                check("t6_overflow", 16'(overflow), 16'd0);
                if (last_cyc >= 0) check("t6_interval", 16'(cyc - last_cyc), 16'd10);
                last_cyc = cyc;
                got_n++;
            end
            if (in_ready && idx < 4) begin
                A = b2b_a[idx]; B = b2b_b[idx]; in_valid = 1'b1;
                exp_q.push_back(b2b_r[idx]);
                idx++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                A = W'($urandom_range(0, 255));
                B = W'($urandom_range(0, 255));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t6_count", 16'(got_n), 16'd4);
        check("t6_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
